uart_rx_param: RTL and testbench

Parametrised asynchronous serial receiver; next generation of the fixed 10-bit-frame receiver. Configurable data width, oversampling ratio, stop-bit count and optional parity. Receives continuously: a new frame can be captured while the previous word waits for acknowledge. Adds per-error flags and overrun detection. Sits between the RXD pad synchroniser domain and the consumer logic that acknowledges each received word.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_baud_tick.sv | 28 ++
 rtl/uart_rx_param.sv | 204 ++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver and transmitter: FSM states,
// parity modes and the frame-length helper.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } rx_state_e;

   typedef enum logic {
      PAR_EVEN = 1'b0,
      PAR_ODD  = 1'b1
   } parity_mode_e;

   // Total bit periods in one frame: start + data + optional parity + stop.
   function automatic int frame_bits(input int data_bits, input int stop_bits, input bit parity_en);
      return 1 + data_bits + (parity_en ? 1 : 0) + stop_bits;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Loadable baud down-counter; tick is high while the count sits at zero.
// Shared by the receiver and the transmitter.
module uart_baud_tick #(
   parameter int WIDTH = 3
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic             tick
);

   logic [WIDTH-1:0] cnt;

   // NOTE: flops are written with <= so every register samples pre-edge values, whatever the statement order.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - WIDTH'(1);
      end
   end

   assign tick = (cnt == '0);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver with framing/parity flags and sticky overrun.
// Define RX_PARITY_EN to insert a parity bit between the data and stop bits.
module uart_rx_param
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 8,
   parameter int STOP_BITS  = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   input  logic                 RXD,
   input  logic                 DATA_ACK,
   output logic [DATA_BITS-1:0] DATA_OUT,
   output logic                 RX_BUSY,
   output logic                 RX_READY,
   output logic                 RX_FRAME_ERR,
   output logic                 RX_PARITY_ERR,
   output logic                 RX_OVERRUN
);

`ifdef RX_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif
   localparam int FRAME_BITS = frame_bits(DATA_BITS, STOP_BITS, PAR_EN);
   localparam int CNT_W      = $clog2(OVERSAMPLE);
   localparam int POS_W      = $clog2(FRAME_BITS);

   localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(OVERSAMPLE / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(OVERSAMPLE - 1);
   localparam logic [POS_W-1:0] LAST_DATA = POS_W'(DATA_BITS);
   localparam logic [POS_W-1:0] LAST_POS  = POS_W'(FRAME_BITS - 1);

   rx_state_e            state_q, state_d;
   logic                 rxd_meta, rxd_sync, rxd_prev;
   logic                 fall, tick;
   logic                 cnt_load;
   logic [CNT_W-1:0]     cnt_val;
   logic                 sample, frame_start, complete;
   logic [POS_W-1:0]     pos_q;
   logic [DATA_BITS-1:0] shreg_q;
   logic                 ferr_pend_q;
   logic                 frame_err_now, par_err_now;

   // Two-flop synchroniser plus edge-detect flop; all idle high so reset never fakes a start edge.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         rxd_meta <= 1'b1;
         rxd_sync <= 1'b1;
         rxd_prev <= 1'b1;
      end else begin
         rxd_meta <= RXD;
         rxd_sync <= rxd_meta;
         rxd_prev <= rxd_sync;
      end
   end

   assign fall = rxd_prev & ~rxd_sync;

   uart_baud_tick #(
      .WIDTH(CNT_W)
   ) u_baud (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .load    (cnt_load),
      .load_val(cnt_val),
      .tick    (tick)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // NOTE: every signal driven here gets a default before the case, so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      cnt_load    = 1'b0;
      cnt_val     = FULL_LOAD;
      sample      = 1'b0;
      frame_start = 1'b0;
      complete    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (fall) begin
               state_d  = ST_START;
               cnt_load = 1'b1;
               cnt_val  = HALF_LOAD;
            end
         end
         ST_START: begin
            if (tick) begin
               if (rxd_sync) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d     = ST_DATA;
                  cnt_load    = 1'b1;
                  frame_start = 1'b1;
               end
            end
         end
         ST_DATA: begin
            if (tick) begin
               sample   = 1'b1;
               cnt_load = 1'b1;
               if (pos_q == LAST_DATA) begin
`ifdef RX_PARITY_EN
                  state_d = ST_PARITY;
`else
                  state_d = ST_STOP;
`endif
               end
            end
         end
`ifdef RX_PARITY_EN
         ST_PARITY: begin
            if (tick) begin
               sample   = 1'b1;
               cnt_load = 1'b1;
               state_d  = ST_STOP;
            end
         end
`endif
         ST_STOP: begin
            if (tick) begin
               sample   = 1'b1;
               cnt_load = 1'b1;
               if (pos_q == LAST_POS) begin
                  complete = 1'b1;
                  state_d  = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // pos_q is the frame position of the next sample: 1..DATA_BITS are data, then parity, then stop.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         pos_q       <= '0;
         shreg_q     <= '0;
         ferr_pend_q <= 1'b0;
      end else if (frame_start) begin
         pos_q       <= POS_W'(1);
         ferr_pend_q <= 1'b0;
      end else if (sample) begin
         pos_q <= pos_q + POS_W'(1);
         if (state_q == ST_DATA)             shreg_q     <= {rxd_sync, shreg_q[DATA_BITS-1:1]};
         if (state_q == ST_STOP && !rxd_sync) ferr_pend_q <= 1'b1;
      end
   end

   // Includes the stop sample being taken in the completion cycle itself.
   assign frame_err_now = ferr_pend_q | ~rxd_sync;

`ifdef RX_PARITY_EN
   localparam parity_mode_e PAR_MODE = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;
   logic par_q;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)                             par_q <= 1'b0;
      else if (sample && state_q == ST_PARITY) par_q <= rxd_sync;
   end

   assign par_err_now = (((^shreg_q) ^ par_q) != PAR_MODE);
`else
   logic unused_parity_odd;
   assign unused_parity_odd = (PARITY_ODD != 0);
   assign par_err_now       = 1'b0;
`endif

   // An ACK in the completion cycle frees the holding register, so the new word wins.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         DATA_OUT      <= '0;
         RX_READY      <= 1'b0;
         RX_FRAME_ERR  <= 1'b0;
         RX_PARITY_ERR <= 1'b0;
         RX_OVERRUN    <= 1'b0;
      end else if (complete) begin
         if (!RX_READY || DATA_ACK) begin
            DATA_OUT      <= shreg_q;
            RX_READY      <= 1'b1;
            RX_FRAME_ERR  <= frame_err_now;
            RX_PARITY_ERR <= par_err_now;
            if (DATA_ACK) RX_OVERRUN <= 1'b0;
         end else begin
            RX_OVERRUN <= 1'b1;
         end
      end else if (DATA_ACK && RX_READY) begin
         RX_READY      <= 1'b0;
         RX_FRAME_ERR  <= 1'b0;
         RX_PARITY_ERR <= 1'b0;
         RX_OVERRUN    <= 1'b0;
      end
   end

   assign RX_BUSY = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param: directed scenarios plus randomized frames
// compared against a word-level receiver model.
module tb_uart_rx_param;

   localparam int DATA_BITS  = 8;
   localparam int OVERSAMPLE = 8;
   localparam int STOP_BITS  = 1;
   localparam int PARITY_ODD = 0;
`ifdef RX_PARITY_EN
   localparam int PAR_BITS = 1;
`else
   localparam int PAR_BITS = 0;
`endif
   localparam int N_BITS = 1 + DATA_BITS + PAR_BITS + STOP_BITS;
   // Cycles from driving the start bit on RXD to RX_READY: 2 synchroniser cycles plus the documented latency.
   localparam int LAT = 2 + OVERSAMPLE / 2 + (N_BITS - 1) * OVERSAMPLE + 1;

   logic                 CLK = 1'b0;
   logic                 RST_N = 1'b0;
   logic                 RXD = 1'b1;
   logic                 DATA_ACK = 1'b0;
   logic [DATA_BITS-1:0] DATA_OUT;
   logic                 RX_BUSY, RX_READY, RX_FRAME_ERR, RX_PARITY_ERR, RX_OVERRUN;

   int total = 0;
   int bad   = 0;

   // Word-level model of the consumer-visible state.
   logic [DATA_BITS-1:0] m_data;
   logic                 m_ready, m_ferr, m_perr, m_ovr;

   wire [4:0] dut_flags = {RX_READY, RX_FRAME_ERR, RX_PARITY_ERR, RX_OVERRUN, RX_BUSY};

   uart_rx_param #(
      .DATA_BITS (DATA_BITS),
      .OVERSAMPLE(OVERSAMPLE),
      .STOP_BITS (STOP_BITS),
      .PARITY_ODD(PARITY_ODD)
   ) dut (
      .CLK          (CLK),
      .RST_N        (RST_N),
      .RXD          (RXD),
      .DATA_ACK     (DATA_ACK),
      .DATA_OUT     (DATA_OUT),
      .RX_BUSY      (RX_BUSY),
      .RX_READY     (RX_READY),
      .RX_FRAME_ERR (RX_FRAME_ERR),
      .RX_PARITY_ERR(RX_PARITY_ERR),
      .RX_OVERRUN   (RX_OVERRUN)
   );

   always #5 CLK = ~CLK;

   initial begin
      #2ms;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [4:0] exp_flags();
      return {m_ready, m_ferr, m_perr, m_ovr, 1'b0};
   endfunction

   function automatic logic good_par(input logic [DATA_BITS-1:0] d);
      return (^d) ^ (PARITY_ODD != 0);
   endfunction

   task automatic model_reset();
      m_data = '0; m_ready = 1'b0; m_ferr = 1'b0; m_perr = 1'b0; m_ovr = 1'b0;
   endtask

   task automatic model_complete(input logic [DATA_BITS-1:0] d, input logic stop_v,
                                 input logic par_v, input bit ack);
      logic ferr, perr;
      ferr = (stop_v == 1'b0);
      perr = (PAR_BITS == 1) && (((^d) ^ par_v) != (PARITY_ODD != 0));
      if (!m_ready || ack) begin
         m_data = d; m_ready = 1'b1; m_ferr = ferr; m_perr = perr;
         if (ack) m_ovr = 1'b0;
      end else begin
         m_ovr = 1'b1;
      end
   endtask

   task automatic model_ack();
      if (m_ready) begin
         m_ready = 1'b0; m_ferr = 1'b0; m_perr = 1'b0; m_ovr = 1'b0;
      end
   endtask

   // All line changes happen 1 time unit after a rising edge.
   task automatic hold(input logic b, input int n);
      RXD = b;
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic ack_pulse();
      DATA_ACK = 1'b1;
      @(posedge CLK);
      #1;
      DATA_ACK = 1'b0;
      model_ack();
   endtask

   // Drives one complete frame; with ack_end, DATA_ACK covers exactly the completion edge.
   task automatic send_frame(input logic [DATA_BITS-1:0] d, input logic stop_v,
                             input logic par_v, input bit ack_end);
      hold(1'b0, OVERSAMPLE);
      for (int i = 0; i < DATA_BITS; i++) hold(d[i], OVERSAMPLE);
      if (PAR_BITS == 1) hold(par_v, OVERSAMPLE);
      for (int s = 0; s < STOP_BITS; s++) begin
         if (ack_end && s == STOP_BITS - 1) begin
            hold(stop_v, OVERSAMPLE / 2 + 2);
            DATA_ACK = 1'b1;
            hold(stop_v, 1);
            DATA_ACK = 1'b0;
            hold(stop_v, OVERSAMPLE / 2 - 3);
         end else begin
            hold(stop_v, OVERSAMPLE);
         end
      end
   endtask

   task automatic test_reset();
      model_reset();
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      total++; if (dut_flags !== 5'b0) begin bad++; $display("FAIL reset_flags got=%b want=%b", dut_flags, 5'b0); end
      total++; if (DATA_OUT !== '0) begin bad++; $display("FAIL reset_data got=%h want=%h", DATA_OUT, '0); end
      @(posedge CLK); #1;
      RST_N = 1'b1;
      hold(1'b1, 4);
   endtask

   task automatic test_basic();
      int lat;
      lat = 0;
      fork
         send_frame(8'hA5, 1'b1, good_par(8'hA5), 1'b0);
         begin : mon
            int  cyc;
            bit  seen;
            cyc  = 0;
            seen = 0;
            while (!seen && cyc < 4 * LAT) begin
               @(posedge CLK);
               cyc++;
               @(negedge CLK);
               if (RX_READY) seen = 1;
            end
            lat = cyc;
         end
      join
      model_complete(8'hA5, 1'b1, good_par(8'hA5), 1'b0);
      @(negedge CLK);
      total++; if (lat !== LAT) begin bad++; $display("FAIL basic_latency got=%0d want=%0d", lat, LAT); end
      total++; if (DATA_OUT !== m_data) begin bad++; $display("FAIL basic_data got=%h want=%h", DATA_OUT, m_data); end
      total++; if (dut_flags !== exp_flags()) begin bad++; $display("FAIL basic_flags got=%b want=%b", dut_flags, exp_flags()); end
      @(posedge CLK); #1;
      ack_pulse();
      @(negedge CLK);
      total++; if (dut_flags !== exp_flags()) begin bad++; $display("FAIL basic_ack got=%b want=%b", dut_flags, exp_flags()); end
      @(posedge CLK); #1;
      hold(1'b1, 4);
   endtask

   task automatic test_glitch();
      int busy_cyc;
      bit rdy_seen;
      busy_cyc = 0;
      rdy_seen = 0;
      RXD = 1'b0;
      for (int i = 0; i < 2 * N_BITS * OVERSAMPLE; i++) begin
         @(negedge CLK);
         if (RX_BUSY)  busy_cyc++;
         if (RX_READY) rdy_seen = 1;
         @(posedge CLK); #1;
         if (i == 2) RXD = 1'b1;
      end
      total++; if (busy_cyc !== OVERSAMPLE / 2) begin bad++; $display("FAIL glitch_busy got=%0d want=%0d", busy_cyc, OVERSAMPLE / 2); end
      total++; if (rdy_seen !== 1'b0) begin bad++; $display("FAIL glitch_ready got=%b want=0", rdy_seen); end
      @(negedge CLK);
      total++; if (dut_flags !== exp_flags()) begin bad++; $display("FAIL glitch_flags got=%b want=%b", dut_flags, exp_flags()); end
      @(posedge CLK); #1;
   endtask

   task automatic test_break();
      bit busy_seen;
      busy_seen = 0;
      send_frame(8'h3C, 1'b0, good_par(8'h3C), 1'b0);
      model_complete(8'h3C, 1'b0, good_par(8'h3C), 1'b0);
      for (int i = 0; i < 2 * N_BITS * OVERSAMPLE; i++) begin
         @(negedge CLK);
         if (RX_BUSY) busy_seen = 1;
         @(posedge CLK); #1;
      end
      @(negedge CLK);
      total++; if (busy_seen !== 1'b0) begin bad++; $display("FAIL break_busy got=%b want=0", busy_seen); end
      total++; if (DATA_OUT !== m_data) begin bad++; $display("FAIL break_data got=%h want=%h", DATA_OUT, m_data); end
      total++; if (dut_flags !== exp_flags()) begin bad++; $display("FAIL break_flags got=%b want=%b", dut_flags, exp_flags()); end
      @(posedge CLK); #1;
      hold(1'b1, 4);
      ack_pulse();
      hold(1'b1, 2);
      send_frame(8'h96, 1'b1, good_par(8'h96), 1'b0);
      model_complete(8'h96, 1'b1, good_par(8'h96), 1'b0);
      @(negedge CLK);
      total++; if (DATA_OUT !== m_data) begin bad++; $display("FAIL break_recover_data got=%h want=%h", DATA_OUT, m_data); end
      total++; if (dut_flags !== exp_flags()) begin bad++; $display("FAIL break_recover_flags got=%b want=%b", dut_flags, exp_flags()); end
      @(posedge CLK); #1;
      ack_pulse();
      hold(1'b1, 4);
   endtask

   task automatic test_back_to_back();
      send_frame(8'h11, 1'b1, good_par(8'h11), 1'b0);
      model_complete(8'h11, 1'b1, good_par(8'h11), 1'b0);
      send_frame(8'h22, 1'b1, good_par(8'h22), 1'b0);
      model_complete(8'h22, 1'b1, good_par(8'h22), 1'b0);
      @(negedge CLK);
      total++; if (DATA_OUT !== 8'h11) begin bad++; $display("FAIL overrun_data got=%h want=%h", DATA_OUT, 8'h11); end
      total++; if (dut_flags !== exp_flags()) begin bad++; $display("FAIL overrun_flags got=%b want=%b", dut_flags, exp_flags()); end
      @(posedge CLK); #1;
      send_frame(8'h11, 1'b1, good_par(8'h11), 1'b0);
      model_complete(8'h11, 1'b1, good_par(8'h11), 1'b0);
      send_frame(8'h22, 1'b1, good_par(8'h22), 1'b1);
      model_complete(8'h22, 1'b1, good_par(8'h22), 1'b1);
      @(negedge CLK);
      total++; if (DATA_OUT !== 8'h22) begin bad++; $display("FAIL ackcomp_data got=%h want=%h", DATA_OUT, 8'h22); end
      total++; if (dut_flags !== exp_flags()) begin bad++; $display("FAIL ackcomp_flags got=%b want=%b", dut_flags, exp_flags()); end
      @(posedge CLK); #1;
      ack_pulse();
      @(negedge CLK);
      total++; if (dut_flags !== exp_flags()) begin bad++; $display("FAIL ackcomp_clear got=%b want=%b", dut_flags, exp_flags()); end
      @(posedge CLK); #1;
      hold(1'b1, 4);
   endtask

`ifdef RX_PARITY_EN
   task automatic test_parity();
      for (int p = 0; p < 2; p++) begin
         send_frame(8'h07, 1'b1, p[0], 1'b0);
         model_complete(8'h07, 1'b1, p[0], 1'b0);
         @(negedge CLK);
         total++; if (RX_PARITY_ERR !== ((PARITY_ODD == 0) ? ~p[0] : p[0])) begin
            bad++; $display("FAIL parity_bit%0d got=%b want=%b", p, RX_PARITY_ERR, (PARITY_ODD == 0) ? ~p[0] : p[0]);
         end
         total++; if (dut_flags !== exp_flags()) begin bad++; $display("FAIL parity_flags%0d got=%b want=%b", p, dut_flags, exp_flags()); end
         @(posedge CLK); #1;
         ack_pulse();
         hold(1'b1, 3);
      end
   endtask
`endif

   task automatic test_reset_mid_frame();
      logic [DATA_BITS-1:0] d;
      send_frame(8'hC3, 1'b1, good_par(8'hC3), 1'b0);
      model_complete(8'hC3, 1'b1, good_par(8'hC3), 1'b0);
      hold(1'b1, 3);
      d = 8'hE7;
      hold(1'b0, OVERSAMPLE);
      for (int i = 0; i < 4; i++) hold(d[i], OVERSAMPLE);
      hold(d[4], OVERSAMPLE / 2);
      #2;
      RST_N = 1'b0;
      model_reset();
      #1;
      total++; if (dut_flags !== exp_flags()) begin bad++; $display("FAIL midreset_flags got=%b want=%b", dut_flags, exp_flags()); end
      total++; if (DATA_OUT !== '0) begin bad++; $display("FAIL midreset_data got=%h want=%h", DATA_OUT, '0); end
      RXD = 1'b1;
      @(posedge CLK); #1;
      hold(1'b1, 3);
      RST_N = 1'b1;
      hold(1'b1, 4);
      send_frame(8'h5A, 1'b1, good_par(8'h5A), 1'b0);
      model_complete(8'h5A, 1'b1, good_par(8'h5A), 1'b0);
      @(negedge CLK);
      total++; if (DATA_OUT !== 8'h5A) begin bad++; $display("FAIL midreset_rx_data got=%h want=%h", DATA_OUT, 8'h5A); end
      total++; if (dut_flags !== exp_flags()) begin bad++; $display("FAIL midreset_rx_flags got=%b want=%b", dut_flags, exp_flags()); end
      @(posedge CLK); #1;
      ack_pulse();
      hold(1'b1, 4);
   endtask

   task automatic test_random();
      logic [DATA_BITS-1:0] d;
      logic                 stop_v, par_v;
      bit                   ack_end;
      for (int n = 0; n < 20; n++) begin
         d       = DATA_BITS'($urandom);
         stop_v  = ($urandom_range(0, 7) != 0);
         par_v   = 1'($urandom_range(0, 1));
         ack_end = ($urandom_range(0, 3) == 0);
         send_frame(d, stop_v, par_v, ack_end);
         model_complete(d, stop_v, par_v, ack_end);
         @(negedge CLK);
         total++; if (DATA_OUT !== m_data) begin bad++; $display("FAIL rand%0d_data got=%h want=%h", n, DATA_OUT, m_data); end
         total++; if (dut_flags !== exp_flags()) begin bad++; $display("FAIL rand%0d_flags got=%b want=%b", n, dut_flags, exp_flags()); end
         @(posedge CLK); #1;
         if ($urandom_range(0, 1) == 1) ack_pulse();
         hold(1'b1, stop_v ? $urandom_range(0, 3) : $urandom_range(1, 4));
      end
      ack_pulse();
      hold(1'b1, 2);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_glitch();
      test_break();
      test_back_to_back();
`ifdef RX_PARITY_EN
      test_parity();
`endif
      test_reset_mid_frame();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
